memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
MEM stage of the 5-stage RV32I pipeline. It consumes the E→M pipeline outputs and drives a req/ready data-memory bus. It formats load data and store strobes/data, stalls the pipeline while the bus is busy, and registers results into the M→W pipeline register for writeback and forwarding.

Parameters:
WAIT_LIMIT, 255, maximum WAIT cycles before bus timeout abort; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  reset, synchronous and active-low
RegWrite_M  input  1  regfile write enable from E/M register
MemWrite_M  input  1  store request
MemRead_M  input  1  load request
ResultSrc_M  input  2  WB mux select: 00 ALU, 01 load data, 10 PC+4
funct3_M  input  3  access size and sign
RD_M  input  5  destination register
PCPlus4_M  input  32  link value
WriteData_M  input  32  store data, forwarded rs2
ALU_Result_M  input  32  effective address or ALU result
Instr_M  input  32  debug instruction
dmem_req  output  1  bus request
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address {ALU_Result_M[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_wstrb  output  4  byte strobes; 0000 on loads
dmem_rdata  input  32  read word, valid when dmem_ready=1
dmem_ready  input  1  access completes this cycle
Stall_M  output  1  to hazard unit; freezes PC, F/D, D/E and E/M registers
MemErr_M  output  1  one-cycle pulse on misaligned access or timeout
RegWrite_W, ResultSrc_W[2], RD_W[5], ALU_Result_W[32], ReadData_W[32], PCPlus4_W[32], Instr_W[32]  outputs  M/W pipeline register contents

Behaviour:
- Reset: synchronous. On a posedge with rst_n=0: state goes to IDLE, wait counter clears, and all *_W outputs clear to 0. While rst_n=0, dmem_req, Stall_M and MemErr_M are forced to 0 combinationally. A reset during WAIT abandons the access, with no W update; the bus must tolerate the dropped request.
- Memory op: MemRead_M|MemWrite_M. Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
- FSM states: IDLE and WAIT.
- IDLE, aligned memory op: dmem_req=1 in the same cycle.
  - If dmem_ready=1: zero-wait completion; W register loads this edge; Stall_M=0.
  - Else: go to WAIT with Stall_M=1.
- WAIT: dmem_req=1 and Stall_M=1 are held; all request fields stay stable because upstream is frozen. On dmem_ready=1: Stall_M=0, W register loads, go to IDLE.
- Timeout: a counter increments each WAIT cycle. When it reaches WAIT_LIMIT without ready: drop the request, pulse MemErr_M, load W with RegWrite_W=0, go to IDLE.
- Misaligned access: no bus request. MemErr_M pulses. W loads with RegWrite_W=0 and ReadData_W=0. No stall.
- Non-memory op: W loads every cycle; latency is 1 cycle M→W.
- Stall_M=1: the W register holds its value. Repeated regfile writes are idempotent, and ResultW forwarding stays valid.
- Loads, with byte lane = addr[1:0]:
  - LB: sign-extend the lane byte. LBU: zero-extend it.
  - LH: sign-extend the half at addr[1]. LHU: zero-extend it.
  - LW: the full word.
  - Any other funct3 yields 0.
- Stores:
  - SB: wstrb=0001<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{half}}.
  - SW: wstrb=1111.
- MemRead_M and MemWrite_M both high is illegal; the load takes priority.
- The FSM samples dmem_ready only while dmem_req=1.

Decomposition:
- Shared package: funct3 load/store encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010), ResultSrc encodings, and FSM state encoding.
- Sub-module load_store_align (combinational): addr[1:0], funct3 and data → wstrb, wdata, formatted read data, misaligned flag.

Test Plan:
- Zero-wait LW to addr 0x100: ready tied high, rdata=0xDEADBEEF → dmem_req one cycle, Stall_M=0, next cycle ReadData_W=0xDEADBEEF, RegWrite_W=1.
- LB at 0x103 with ready after 3 cycles: rdata=0x80FF_FF7F → Stall_M=1 for exactly 3 cycles, ReadData_W=0xFFFFFF80; LBU same case → 0x00000080.
- SH at 0x202 with WriteData_M=0x1234ABCD → dmem_addr=0x200, wstrb=1100, wdata=0xABCDABCD, we=1.
- LW at 0x101 → no dmem_req, MemErr_M one pulse, RegWrite_W=0, no stall.
- WAIT_LIMIT=4, ready never asserted → Stall_M for 4 cycles, then MemErr_M pulse, request dropped, return to IDLE; reset mid-WAIT → next cycle dmem_req=0 and all W outputs 0.

Source files
------------

// File: rtl/memory_cycle_pkg.sv
// Shared encodings for the MEM stage: funct3 access codes, WB mux selects,
// FSM states and the layout of the M->W pipeline register.
// Imported by the align sub-module, the top and the testbench.
package memory_cycle_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Writeback mux selects
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // M->W pipeline register contents
    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } mw_t;

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory request/ready bus between the MEM stage and the memory.
// master: MEM stage (drives request fields); slave: memory (drives rdata/ready).
// Ports: dmem_req/we/addr/wdata/wstrb (master->slave), dmem_rdata/ready (slave->master).
interface memory_cycle_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/memory_cycle_load_store_align.sv
// Byte-lane formatting: store strobes/replicated data, load extract+extend, misalignment.
// Latency: purely combinational.
// Backpressure: none; ports: addr_lo_i/funct3_i/is_*_i/store_dat_i/load_word_i in, wstrb_o/wdata_o/load_dat_o/misaligned_o out.
module load_store_align
    import memory_cycle_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [31:0] store_dat_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_dat_o,
    output logic        misaligned_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = load_word_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_half = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

    always_comb begin
        load_dat_o = 32'h0;
        case (funct3_i)
            F3_LB:   load_dat_o = {{24{lane_byte[7]}}, lane_byte};
            F3_LBU:  load_dat_o = {24'h0, lane_byte};
            F3_LH:   load_dat_o = {{16{lane_half[15]}}, lane_half};
            F3_LHU:  load_dat_o = {16'h0, lane_half};
            F3_LW:   load_dat_o = load_word_i;
            default: load_dat_o = 32'h0;
        endcase
    end

    // Strobes stay zero for anything that is not a store so the memory
    // never sees a partial write on a load.
    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = store_dat_i;
        if (is_store_i) begin
            case (funct3_i)
                F3_SB: begin
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{store_dat_i[7:0]}};
                end
                F3_SH: begin
                    wstrb_o = 4'b0011 << addr_lo_i;
                    wdata_o = {2{store_dat_i[15:0]}};
                end
                F3_SW:   wstrb_o = 4'b1111;
                default: wstrb_o = 4'b0000;
            endcase
        end
    end

    always_comb begin
        misaligned_o = 1'b0;
        if (is_load_i) begin
            case (funct3_i)
                F3_LH, F3_LHU: misaligned_o = addr_lo_i[0];
                F3_LW:         misaligned_o = |addr_lo_i;
                default:       misaligned_o = 1'b0;
            endcase
        end else if (is_store_i) begin
            case (funct3_i)
                F3_SH:   misaligned_o = addr_lo_i[0];
                F3_SW:   misaligned_o = |addr_lo_i;
                default: misaligned_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// RV32I MEM stage: drives the dmem bus, formats load/store data, registers M->W.
// Latency: 1 cycle M->W; memory ops complete on the first cycle dmem_ready=1.
// Backpressure: Stall_M held while the bus is busy (bounded by WAIT_LIMIT), W holds meanwhile.
// Ports: clk/rst_n; E/M inputs (*_M); dmem bus interface (master); Stall_M, MemErr_M; M/W outputs (*_W).
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 RegWrite_M,
    input  logic                 MemWrite_M,
    input  logic                 MemRead_M,
    input  logic [1:0]           ResultSrc_M,
    input  logic [2:0]           funct3_M,
    input  logic [4:0]           RD_M,
    input  logic [31:0]          PCPlus4_M,
    input  logic [31:0]          WriteData_M,
    input  logic [31:0]          ALU_Result_M,
    input  logic [31:0]          Instr_M,

    memory_cycle_if.master       dmem,

    output logic                 Stall_M,
    output logic                 MemErr_M,

    output logic                 RegWrite_W,
    output logic [1:0]           ResultSrc_W,
    output logic [4:0]           RD_W,
    output logic [31:0]          ALU_Result_W,
    output logic [31:0]          ReadData_W,
    output logic [31:0]          PCPlus4_W,
    output logic [31:0]          Instr_W
);

    localparam int unsigned         CNT_W   = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]    LIMIT_C = CNT_W'(WAIT_LIMIT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mw_t               w_q, w_d;

    logic              is_load, is_store, mem_op;
    logic              misaligned, timeout;
    logic [31:0]       load_dat;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              req, stall, err, w_load, w_regwrite;
    logic [31:0]       w_rdata;

    // Load wins when both enables are (illegally) high.
    assign is_load  = MemRead_M;
    assign is_store = MemWrite_M & ~MemRead_M;
    assign mem_op   = MemRead_M | MemWrite_M;

    load_store_align u_align (
        .addr_lo_i    (ALU_Result_M[1:0]),
        .funct3_i     (funct3_M),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .store_dat_i  (WriteData_M),
        .load_word_i  (dmem.dmem_rdata),
        .wstrb_o      (wstrb),
        .wdata_o      (wdata),
        .load_dat_o   (load_dat),
        .misaligned_o (misaligned)
    );

    // The counter already includes the IDLE cycle that issued the request,
    // so the stall lasts exactly WAIT_LIMIT cycles before the abort cycle.
    assign timeout = (WAIT_LIMIT != 0) && (cnt_q == LIMIT_C);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req        = 1'b0;
        stall      = 1'b0;
        err        = 1'b0;
        w_load     = 1'b1;
        w_regwrite = RegWrite_M;
        w_rdata    = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        err        = 1'b1;
                        w_regwrite = 1'b0;
                    end else begin
                        req = 1'b1;
                        if (dmem.dmem_ready) begin
                            w_rdata = is_load ? load_dat : 32'h0;
                        end else begin
                            stall   = 1'b1;
                            w_load  = 1'b0;
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (timeout) begin
                    // Request is dropped this cycle; the instruction retires without a write.
                    err        = 1'b1;
                    w_regwrite = 1'b0;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else begin
                    req = 1'b1;
                    if (dmem.dmem_ready) begin
                        w_rdata = is_load ? load_dat : 32'h0;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        stall  = 1'b1;
                        w_load = 1'b0;
                        if (WAIT_LIMIT != 0) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!rst_n) begin
            req   = 1'b0;
            stall = 1'b0;
            err   = 1'b0;
        end
    end

    always_comb begin
        w_d            = w_q;
        w_d.reg_write  = w_regwrite;
        w_d.result_src = ResultSrc_M;
        w_d.rd         = RD_M;
        w_d.alu_result = ALU_Result_M;
        w_d.read_data  = w_rdata;
        w_d.pc_plus4   = PCPlus4_M;
        w_d.instr      = Instr_M;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_load) begin
                w_q <= w_d;
            end
        end
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {ALU_Result_M[31:2], 2'b00};
    assign dmem.dmem_wdata = wdata;
    assign dmem.dmem_wstrb = wstrb;

    assign Stall_M      = stall;
    assign MemErr_M     = err;

    assign RegWrite_W   = w_q.reg_write;
    assign ResultSrc_W  = w_q.result_src;
    assign RD_W         = w_q.rd;
    assign ALU_Result_W = w_q.alu_result;
    assign ReadData_W   = w_q.read_data;
    assign PCPlus4_W    = w_q.pc_plus4;
    assign Instr_W      = w_q.instr;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: stimulus pushes expected per-instruction
// results, a negedge monitor compares bus activity, stall/error counts and W contents.
module tb_memory_cycle;
    import memory_cycle_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWrite_M, MemWrite_M, MemRead_M;
    logic [1:0]  ResultSrc_M;
    logic [2:0]  funct3_M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4_M, WriteData_M, ALU_Result_M, Instr_M;
    logic        Stall_M, MemErr_M;
    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [4:0]  RD_W;
    logic [31:0] ALU_Result_W, ReadData_W, PCPlus4_W, Instr_W;

    memory_cycle_if dmem();

    memory_cycle #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M),
        .ResultSrc_M(ResultSrc_M), .funct3_M(funct3_M), .RD_M(RD_M),
        .PCPlus4_M(PCPlus4_M), .WriteData_M(WriteData_M), .ALU_Result_M(ALU_Result_M),
        .Instr_M(Instr_M), .dmem(dmem), .Stall_M(Stall_M), .MemErr_M(MemErr_M),
        .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .RD_W(RD_W),
        .ALU_Result_W(ALU_Result_W), .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W),
        .Instr_W(Instr_W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu, pc4, instr, rdata;
        bit          chk_rdata;
        int          n_stall, n_req, n_err;
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    bit   w_pending = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // ---------------- reference model (straight from the ISA rules) ----------------
    function automatic bit is_mis(input bit ld, input logic [2:0] f3, input logic [1:0] a);
        int sz;
        sz = 0;
        if (f3 == 3'd1 || (ld && f3 == 3'd5)) sz = 2;
        else if (f3 == 3'd2) sz = 4;
        return (sz != 0) && ((int'(a) % sz) != 0);
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0:    return 4'(1 << int'(a));
            3'd1:    return 4'(3 << int'(a));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return (w & 32'hFF) * 32'h01010101;
            3'd1:    return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    // n = number of cycles the memory keeps dmem_ready low before answering.
    task automatic do_instr(input bit rd_en, input bit wr_en, input bit regw, input logic [1:0] rsrc,
                            input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [31:0] word, input int n);
        exp_t e;
        bit   ld, st, memop, mis;
        int   cycles;
        ld = rd_en; st = wr_en && !rd_en; memop = rd_en || wr_en;
        mis = memop && is_mis(ld, f3, alu[1:0]);
        e.regw = regw; e.rsrc = rsrc; e.rd = rd; e.alu = alu;
        e.pc4 = $urandom; e.instr = $urandom; e.rdata = 32'h0; e.chk_rdata = 1'b0;
        e.we = st; e.addr = alu & 32'hFFFF_FFFC;
        e.wstrb = st ? st_strb(f3, alu[1:0]) : 4'h0;
        e.wdata = st_data(f3, wd); e.chk_wdata = st;
        if (!memop) begin
            e.n_stall = 0; e.n_req = 0; e.n_err = 0; cycles = 1;
        end else if (mis) begin
            e.n_stall = 0; e.n_req = 0; e.n_err = 1; cycles = 1;
            e.regw = 1'b0; e.chk_rdata = 1'b1;
        end else if (n >= LIMIT) begin
            e.n_stall = LIMIT; e.n_req = LIMIT; e.n_err = 1; cycles = LIMIT + 1;
            e.regw = 1'b0;
        end else begin
            e.n_stall = n; e.n_req = n + 1; e.n_err = 0; cycles = n + 1;
            if (ld) begin e.rdata = load_fmt(f3, alu[1:0], word); e.chk_rdata = 1'b1; end
        end
        sb_q.push_back(e);
        RegWrite_M = regw; MemRead_M = rd_en; MemWrite_M = wr_en; ResultSrc_M = rsrc;
        funct3_M = f3; RD_M = rd; ALU_Result_M = alu; WriteData_M = wd;
        PCPlus4_M = e.pc4; Instr_M = e.instr; dmem.dmem_rdata = word;
        for (int k = 0; k < cycles; k++) begin
            if (memop && !mis) dmem.dmem_ready = (k == n) && (n < LIMIT);
            else               dmem.dmem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, "_RegWrite_W"},  32'(RegWrite_W),  32'h0);
        chk({tag, "_ResultSrc_W"}, 32'(ResultSrc_W), 32'h0);
        chk({tag, "_RD_W"},        32'(RD_W),        32'h0);
        chk({tag, "_ALU_W"},       ALU_Result_W,     32'h0);
        chk({tag, "_ReadData_W"},  ReadData_W,       32'h0);
        chk({tag, "_PCPlus4_W"},   PCPlus4_W,        32'h0);
        chk({tag, "_Instr_W"},     Instr_W,          32'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t head, cur;
        int   st_cnt, rq_cnt, er_cnt;
        st_cnt = 0; rq_cnt = 0; er_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (w_pending) begin
                    w_pending = 1'b0;
                    chk("W_RegWrite",  32'(RegWrite_W),  32'(cur.regw));
                    chk("W_ResultSrc", 32'(ResultSrc_W), 32'(cur.rsrc));
                    chk("W_RD",        32'(RD_W),        32'(cur.rd));
                    chk("W_ALU",       ALU_Result_W,     cur.alu);
                    chk("W_PCPlus4",   PCPlus4_W,        cur.pc4);
                    chk("W_Instr",     Instr_W,          cur.instr);
                    if (cur.chk_rdata) chk("W_ReadData", ReadData_W, cur.rdata);
                end
                if (sb_q.size() > 0) begin
                    head = sb_q[0];
                    if (dmem.dmem_req) begin
                        rq_cnt++;
                        chk("bus_addr",  dmem.dmem_addr,         head.addr);
                        chk("bus_we",    32'(dmem.dmem_we),      32'(head.we));
                        chk("bus_wstrb", 32'(dmem.dmem_wstrb),   32'(head.wstrb));
                        if (head.chk_wdata) chk("bus_wdata", dmem.dmem_wdata, head.wdata);
                    end
                    if (Stall_M)  st_cnt++;
                    if (MemErr_M) er_cnt++;
                    if (!Stall_M) begin
                        chk("stall_cycles", 32'(st_cnt), 32'(head.n_stall));
                        chk("req_cycles",   32'(rq_cnt), 32'(head.n_req));
                        chk("err_pulses",   32'(er_cnt), 32'(head.n_err));
                        cur = sb_q.pop_front();
                        w_pending = 1'b1;
                        st_cnt = 0; rq_cnt = 0; er_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          rd_en, wr_en;
        int          kind, n;
        logic [2:0]  f3;
        logic [1:0]  rsrc;
        RegWrite_M = 1'b1; MemRead_M = 1'b1; MemWrite_M = 1'b0; ResultSrc_M = RES_LOAD;
        funct3_M = F3_LW; RD_M = 5'd3; PCPlus4_M = 32'h4; WriteData_M = 32'h0;
        ALU_Result_M = 32'h100; Instr_M = 32'h13;
        dmem.dmem_rdata = 32'h0; dmem.dmem_ready = 1'b0;

        // Reset forces the bus/status outputs low even with a pending load or a misaligned op.
        @(negedge clk);
        chk("rst_req",   32'(dmem.dmem_req), 32'h0);
        chk("rst_stall", 32'(Stall_M),       32'h0);
        ALU_Result_M = 32'h101;
        @(negedge clk);
        chk("rst_memerr", 32'(MemErr_M), 32'h0);
        @(posedge clk); #1;
        chk_w_zero("rst");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        do_instr(1, 0, 1, RES_LOAD, F3_LW,  5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        do_instr(1, 0, 1, RES_LOAD, F3_LB,  5'd6, 32'h103, 32'h0, 32'h80FFFF7F, 3);
        do_instr(1, 0, 1, RES_LOAD, F3_LBU, 5'd7, 32'h103, 32'h0, 32'h80FFFF7F, 3);
        do_instr(0, 1, 0, RES_ALU,  F3_SH,  5'd0, 32'h202, 32'h1234ABCD, 32'h0, 0);
        do_instr(1, 0, 1, RES_LOAD, F3_LW,  5'd8, 32'h101, 32'h0, 32'h11223344, 0);
        do_instr(1, 0, 1, RES_LOAD, F3_LW,  5'd9, 32'h300, 32'h0, 32'h55667788, 100);
        do_instr(0, 0, 1, RES_PC4,  3'd0,   5'd1, 32'h0BADF00D, 32'h0, 32'h0, 0);
        do_instr(1, 1, 1, RES_LOAD, F3_LH,  5'd2, 32'h402, 32'hFFFFFFFF, 32'h8001_7FFF, 1);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            kind  = $urandom_range(0, 9);
            rd_en = (kind >= 3 && kind <= 5) || kind == 9;
            wr_en = (kind >= 6 && kind <= 8) || kind == 9;
            f3    = (wr_en && !rd_en) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       rsrc = RES_ALU;
                1:       rsrc = RES_LOAD;
                default: rsrc = RES_PC4;
            endcase
            n = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            do_instr(rd_en, wr_en, 1'($urandom_range(0, 1)), rsrc, f3, 5'($urandom),
                     $urandom, $urandom, $urandom, n);
        end

        // Drain with a harmless non-memory op on the inputs.
        MemRead_M = 1'b0; MemWrite_M = 1'b0; RegWrite_M = 1'b0; dmem.dmem_ready = 1'b0;
        for (int i = 0; i < 20 && (sb_q.size() != 0 || w_pending); i++) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0 || w_pending) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        mon_en = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a wait: request must vanish and W must clear.
        RegWrite_M = 1'b1; MemRead_M = 1'b1; funct3_M = F3_LW; ALU_Result_M = 32'h40;
        RD_M = 5'd4; dmem.dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_req",   32'(dmem.dmem_req), 32'h1);
        chk("wait_stall", 32'(Stall_M),       32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req",   32'(dmem.dmem_req), 32'h0);
        chk("midrst_stall", 32'(Stall_M),       32'h0);
        @(posedge clk); #1;
        chk_w_zero("midrst");
        rst_n = 1'b1;
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
        @(negedge clk);
        chk("postrst_req",    32'(dmem.dmem_req), 32'h0);
        chk("postrst_stall",  32'(Stall_M),       32'h0);
        chk("postrst_memerr", 32'(MemErr_M),      32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
